// File: rtl/axis_fork_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : axis_fork_dispatcher
// Description : AXI-Stream 1-to-M dispatcher. Each input beat goes to channel
//               0 (single), to the next free channel (round-robin) or to all
//               channels (broadcast). After the tlast beat, one all-ones end
//               marker with tlast=1 is sent on every channel. Defining the
//               macro AXIS_FORK_BEAT_CNT_EN adds the frame_beats counter port.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_fork_dispatcher #(
  parameter int M_COUNT        = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int BEAT_CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    mode,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  input  logic [M_COUNT-1:0]            m_axis_tready,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_COUNT-1:0]            m_axis_tlast,
  output logic [M_COUNT-1:0]            m_axis_tvalid
`ifdef AXIS_FORK_BEAT_CNT_EN
  ,
  output logic [BEAT_CNT_WIDTH-1:0]     frame_beats
`endif
);

  localparam int         PTR_W      = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam logic [1:0] MODE_RR    = 2'd1;
  localparam logic [1:0] MODE_BCAST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_END    = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      eff_mode_q, eff_mode_d;
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [M_COUNT-1:0]              pend_q, pend_d;
  logic [M_COUNT-1:0]              tvalid_q, tvalid_d;
  logic [M_COUNT-1:0]              tlast_q, tlast_d;
  logic [M_COUNT*DATA_WIDTH-1:0]   tdata_q, tdata_d;

  logic [M_COUNT-1:0]              free;
  logic [M_COUNT-1:0]              load;
  logic [1:0]                      raw_mode;
  logic [1:0]                      cur_mode;
  logic                            s_ready;
  logic                            accept;
  logic [PTR_W-1:0]                rr_sel;
  logic                            rr_found;
  int                              rr_idx;

  assign free     = ~tvalid_q | m_axis_tready;
  // Mode is live only while idle; reserved encoding 3 folds onto single.
  assign raw_mode = (state_q == ST_IDLE) ? mode : eff_mode_q;
  assign cur_mode = (raw_mode == 2'd3) ? 2'd0 : raw_mode;

  // Round-robin pick: first free channel strictly after rr_ptr, wrapping.
  always_comb begin
    rr_sel   = rr_ptr_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 1; k <= M_COUNT; k++) begin
      rr_idx = (int'(rr_ptr_q) + k) % M_COUNT;
      if (!rr_found && free[rr_idx]) begin
        rr_sel   = PTR_W'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  // Input ready and target-channel mask for the current dispatch mode.
  always_comb begin
    s_ready = 1'b0;
    load    = '0;
    case (cur_mode)
      MODE_RR: begin
        s_ready = |free;
        load    = {{(M_COUNT-1){1'b0}}, 1'b1} << rr_sel;
      end
      MODE_BCAST: begin
        s_ready = &free;
        load    = '1;
      end
      default: begin
        s_ready = free[0];
        load    = {{(M_COUNT-1){1'b0}}, 1'b1};
      end
    endcase
    if (state_q == ST_END || !rst_n) s_ready = 1'b0;
  end

  assign s_axis_tready = s_ready;
  assign accept        = s_ready & s_axis_tvalid;

  // Next-state, channel register loads and end-marker bookkeeping.
  always_comb begin
    state_d    = state_q;
    eff_mode_d = eff_mode_q;
    rr_ptr_d   = rr_ptr_q;
    pend_d     = pend_q;
    tvalid_d   = tvalid_q & ~m_axis_tready;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;

    for (int i = 0; i < M_COUNT; i++) begin
      if (accept && load[i]) begin
        tvalid_d[i]                           = 1'b1;
        tdata_d[i*DATA_WIDTH +: DATA_WIDTH]   = s_axis_tdata;
        tlast_d[i]                            = 1'b0;
      end else if (state_q == ST_END && pend_q[i] && free[i]) begin
        tvalid_d[i]                           = 1'b1;
        tdata_d[i*DATA_WIDTH +: DATA_WIDTH]   = '1;
        tlast_d[i]                            = 1'b1;
        pend_d[i]                             = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          eff_mode_d = mode;
          state_d    = s_axis_tlast ? ST_END : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept && s_axis_tlast) state_d = ST_END;
      end
      ST_END: begin
        // Leave once every marker is loaded and none is left unaccepted.
        if (pend_q == '0 && (tvalid_q & tlast_q & ~m_axis_tready) == '0) begin
          state_d    = ST_IDLE;
          eff_mode_d = 2'd0;
          pend_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept && s_axis_tlast) pend_d = '1;
    if (accept && cur_mode == MODE_RR) rr_ptr_d = rr_sel;
  end

  // State and channel registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      eff_mode_q <= 2'd0;
      rr_ptr_q   <= PTR_W'(M_COUNT - 1);
      pend_q     <= '0;
      tvalid_q   <= '0;
      tdata_q    <= '0;
      tlast_q    <= '0;
    end else begin
      state_q    <= state_d;
      eff_mode_q <= eff_mode_d;
      rr_ptr_q   <= rr_ptr_d;
      pend_q     <= pend_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;

`ifdef AXIS_FORK_BEAT_CNT_EN
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [BEAT_CNT_WIDTH-1:0] frame_beats_q, frame_beats_d;
  logic [BEAT_CNT_WIDTH-1:0] cnt_inc;

  // Saturating per-frame beat count, published when the tlast beat lands.
  always_comb begin
    cnt_inc       = (beat_cnt_q == '1) ? beat_cnt_q
                                       : beat_cnt_q + BEAT_CNT_WIDTH'(1);
    beat_cnt_d    = beat_cnt_q;
    frame_beats_d = frame_beats_q;
    if (accept) begin
      if (s_axis_tlast) begin
        frame_beats_d = cnt_inc;
        beat_cnt_d    = '0;
      end else begin
        beat_cnt_d    = cnt_inc;
      end
    end
  end

  // Beat counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q    <= '0;
      frame_beats_q <= '0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      frame_beats_q <= frame_beats_d;
    end
  end

  assign frame_beats = frame_beats_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_fork_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_fork_dispatcher
// Description : Self-checking bench for axis_fork_dispatcher. A behavioural
//               model of the dispatch rules is compared against the DUT every
//               cycle; directed scenarios add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_fork_dispatcher;
  localparam int M   = 4;
  localparam int DW  = 64;
  localparam int BCW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            s_tready;
  logic [DW-1:0]   s_tdata = '0;
  logic            s_tlast = 1'b0;
  logic            s_tvalid = 1'b0;
  logic [M-1:0]    m_tready = '0;
  logic [M*DW-1:0] m_tdata;
  logic [M-1:0]    m_tlast;
  logic [M-1:0]    m_tvalid;
`ifdef AXIS_FORK_BEAT_CNT_EN
  logic [BCW-1:0]  frame_beats;
`endif

  int checks = 0;
  int errors = 0;

  axis_fork_dispatcher #(.M_COUNT(M), .DATA_WIDTH(DW), .BEAT_CNT_WIDTH(BCW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode          (mode),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid)
`ifdef AXIS_FORK_BEAT_CNT_EN
    ,
    .frame_beats   (frame_beats)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: frame phase (0 idle, 1 streaming, 2 flushing markers),
  // per-channel register contents and the round-robin history.
  int            ms = 0;
  logic [1:0]    meff = 2'd0;
  int            mptr = M - 1;
  logic [M-1:0]  mvalid = '0;
  logic [M-1:0]  mlast = '0;
  logic [M-1:0]  mpend = '0;
  logic [DW-1:0] mdata [M];
`ifdef AXIS_FORK_BEAT_CNT_EN
  logic [BCW-1:0] mcnt = '0;
  logic [BCW-1:0] mframe = '0;
`endif

  // Handshake log entries: {channel[3:0], tlast, data}
  logic [68:0] logq [$];

  function automatic int model_mode();
    int md;
    md = (ms == 0) ? int'(mode) : int'(meff);
    if (md == 3) md = 0;
    return md;
  endfunction

  function automatic logic model_ready();
    logic [M-1:0] fr;
    int md;
    fr = ~mvalid | m_tready;
    md = model_mode();
    if (!rst_n || ms == 2) return 1'b0;
    if (md == 1) return |fr;
    if (md == 2) return &fr;
    return fr[0];
  endfunction

  task automatic chk(input string nm, input int ch, input logic [DW:0] got, input logic [DW:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ch%0d got %h expected %h at %0t", nm, ch, got, exp, $time);
    end
  endtask

  function automatic int lcount(int ch);
    int c = 0;
    foreach (logq[j]) if (int'(logq[j][68:65]) == ch) c++;
    return c;
  endfunction

  function automatic logic [DW:0] lget(int ch, int n);
    int c = 0;
    foreach (logq[j]) begin
      if (int'(logq[j][68:65]) == ch) begin
        if (c == n) return logq[j][DW:0];
        c++;
      end
    end
    return {1'b0, 64'hBAD0_BAD0_BAD0_BAD0};
  endfunction

  task automatic lit_log(input int ch, input int n, input logic l, input logic [DW-1:0] d);
    chk($sformatf("log_entry%0d", n), ch, lget(ch, n), {l, d});
  endtask

  // Model update on every rising edge from pre-edge inputs and model state.
  always @(posedge clk) begin : model
    logic [M-1:0] fr;
    logic [M-1:0] oldpend;
    logic [M-1:0] outstanding;
    logic         acc;
    int           md;
    int           sel;
    if (!rst_n) begin
      ms = 0; meff = 2'd0; mptr = M - 1;
      mvalid = '0; mlast = '0; mpend = '0;
      for (int i = 0; i < M; i++) mdata[i] = '0;
`ifdef AXIS_FORK_BEAT_CNT_EN
      mcnt = '0; mframe = '0;
`endif
    end else begin
      acc         = s_tvalid && model_ready();
      md          = model_mode();
      fr          = ~mvalid | m_tready;
      outstanding = mvalid & mlast & ~m_tready;
      oldpend     = mpend;
      mvalid      = mvalid & ~m_tready;
      if (acc) begin
        sel = -1;
        if (md == 1) begin
          for (int k = 1; k <= M; k++)
            if (sel < 0 && fr[(mptr + k) % M]) sel = (mptr + k) % M;
          mptr = sel;
        end
        for (int i = 0; i < M; i++) begin
          if (md == 2 || (md == 1 && i == sel) || (md == 0 && i == 0)) begin
            mvalid[i] = 1'b1; mdata[i] = s_tdata; mlast[i] = 1'b0;
          end
        end
`ifdef AXIS_FORK_BEAT_CNT_EN
        if (s_tlast) begin mframe = mcnt + 1; mcnt = '0; end
        else mcnt = mcnt + 1;
`endif
      end
      if (ms == 2) begin
        for (int i = 0; i < M; i++) begin
          if (oldpend[i] && fr[i]) begin
            mvalid[i] = 1'b1; mdata[i] = '1; mlast[i] = 1'b1; mpend[i] = 1'b0;
          end
        end
      end
      case (ms)
        0: if (acc) begin meff = mode; ms = s_tlast ? 2 : 1; end
        1: if (acc && s_tlast) ms = 2;
        default: if (oldpend == '0 && outstanding == '0) begin ms = 0; meff = 2'd0; end
      endcase
      if (acc && s_tlast) mpend = '1;
    end
  end

  // Compare DUT against the model on the falling edge; log handshakes.
  always @(negedge clk) begin
    chk("s_tready", 0, {64'd0, s_tready}, {64'd0, model_ready()});
    for (int i = 0; i < M; i++) begin
      chk("tvalid", i, {64'd0, m_tvalid[i]}, {64'd0, mvalid[i]});
      if (mvalid[i])
        chk("tlast_tdata", i, {m_tlast[i], m_tdata[i*DW +: DW]}, {mlast[i], mdata[i]});
      if (m_tvalid[i] && m_tready[i])
        logq.push_back({4'(i), m_tlast[i], m_tdata[i*DW +: DW]});
    end
`ifdef AXIS_FORK_BEAT_CNT_EN
    chk("frame_beats", 0, {33'd0, frame_beats}, {33'd0, mframe});
`endif
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    logic acc;
    int   t;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    acc = 1'b0; t = 0;
    while (!acc) begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); #1;
      t++;
      if (!acc && t > 100) begin
        checks++; errors++;
        $display("FAIL send_timeout ch0 got no accept expected accept for data %h", d);
        break;
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog ch0 got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    chk("rst_tvalid", 0, {61'd0, m_tvalid}, '0);
    chk("rst_tready", 0, {64'd0, s_tready}, '0);
    chk("rst_tdata0", 0, {m_tlast[0], m_tdata[DW-1:0]}, '0);
    rst_n = 1'b1;
    cyc(1);

    // Broadcast frame of three beats
    mode = 2'd2; m_tready = '1; logq.delete();
    send(64'h1, 1'b0); send(64'h2, 1'b0); send(64'h3, 1'b1);
    cyc(6);
    for (int ch = 0; ch < M; ch++) begin
      chk("bcast_count", ch, 65'(lcount(ch)), 65'd4);
      lit_log(ch, 0, 1'b0, 64'h1);
      lit_log(ch, 1, 1'b0, 64'h2);
      lit_log(ch, 2, 1'b0, 64'h3);
      lit_log(ch, 3, 1'b1, '1);
    end
`ifdef AXIS_FORK_BEAT_CNT_EN
    chk("frame_beats_lit", 0, {33'd0, frame_beats}, 65'd3);
`endif

    // Round-robin after reset, five beats
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    mode = 2'd1; m_tready = '1; logq.delete();
    for (int b = 0; b < 5; b++) send(64'h10 + 64'(b), (b == 4));
    cyc(6);
    chk("rr_count", 0, 65'(lcount(0)), 65'd3);
    lit_log(0, 0, 1'b0, 64'h10);
    lit_log(0, 1, 1'b0, 64'h14);
    lit_log(0, 2, 1'b1, '1);
    for (int ch = 1; ch < M; ch++) begin
      chk("rr_count", ch, 65'(lcount(ch)), 65'd2);
      lit_log(ch, 0, 1'b0, 64'h10 + 64'(ch));
      lit_log(ch, 1, 1'b1, '1);
    end

    // Round-robin stall with only channel 2 ready; mode change mid-frame ignored
    mode = 2'd1; m_tready = '0; logq.delete();
    send(64'h20, 1'b0);
    mode = 2'd2;
    send(64'h21, 1'b0); send(64'h22, 1'b0); send(64'h23, 1'b0);
    s_tvalid = 1'b1; s_tdata = 64'h24;
    cyc(3);
    chk("rr_stall_ready", 0, {64'd0, s_tready}, '0);
    m_tready = 4'b0100;
    send(64'h24, 1'b0);
    chk("rr_ch2_tdata", 2, {m_tlast[2], m_tdata[2*DW +: DW]}, {1'b0, 64'h24});
    send(64'h25, 1'b1);
    m_tready = '1;
    cyc(8);
    lit_log(2, 0, 1'b0, 64'h21);
    lit_log(2, 1, 1'b0, 64'h24);
    lit_log(2, 2, 1'b0, 64'h25);
    lit_log(2, 3, 1'b1, '1);
    lit_log(0, 0, 1'b0, 64'h23);
    lit_log(0, 1, 1'b1, '1);

    // Broadcast backpressure on channel 0 only
    mode = 2'd2; m_tready = '0; logq.delete();
    send(64'h30, 1'b0);
    m_tready = 4'b1110;
    s_tvalid = 1'b1; s_tdata = 64'h31;
    cyc(3);
    chk("bcast_stall_ready", 0, {64'd0, s_tready}, '0);
    m_tready = '1;
    send(64'h31, 1'b0); send(64'h32, 1'b1);
    cyc(6);
    for (int ch = 0; ch < M; ch++) begin
      chk("bcast_bp_count", ch, 65'(lcount(ch)), 65'd4);
      lit_log(ch, 0, 1'b0, 64'h30);
      lit_log(ch, 1, 1'b0, 64'h31);
    end

    // END phase with staggered channel readiness
    mode = 2'd2; m_tready = '1; logq.delete();
    send(64'h40, 1'b1);
    m_tready = '0;
    cyc(2);
    m_tready = 4'b0001; cyc(1);
    m_tready = 4'b0011;
    chk("end_ready_low", 0, {64'd0, s_tready}, '0);
    cyc(1);
    m_tready = 4'b0111; cyc(1);
    m_tready = 4'b1111; cyc(4);
    for (int ch = 0; ch < M; ch++) begin
      chk("end_count", ch, 65'(lcount(ch)), 65'd2);
      lit_log(ch, 1, 1'b1, '1);
    end
    chk("end_back_idle", 0, {64'd0, s_tready}, 65'd1);

    // Reset mid-frame in broadcast, then round-robin restarts at channel 0
    mode = 2'd2; m_tready = '1;
    send(64'h50, 1'b0);
    m_tready = '0;
    cyc(1);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    chk("midrst_tvalid", 0, {61'd0, m_tvalid}, '0);
    mode = 2'd1; m_tready = '1; logq.delete();
    send(64'h60, 1'b0); send(64'h61, 1'b1);
    cyc(6);
    lit_log(0, 0, 1'b0, 64'h60);
    lit_log(1, 0, 1'b0, 64'h61);

    // Reserved mode behaves as single
    mode = 2'd3; m_tready = '1; logq.delete();
    send(64'h70, 1'b0);
    mode = 2'd1;
    send(64'h71, 1'b1);
    cyc(6);
    chk("mode3_count0", 0, 65'(lcount(0)), 65'd3);
    lit_log(0, 0, 1'b0, 64'h70);
    lit_log(0, 1, 1'b0, 64'h71);
    lit_log(0, 2, 1'b1, '1);
    chk("mode3_count1", 1, 65'(lcount(1)), 65'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
